// File: rtl/adder_bist_4bit.sv
// rtl/adder_bist_4bit.sv - exhaustive BIST sequencer/checker for a 4-bit ripple adder
// Optional first-failure capture is built when ADDER_BIST_FIRSTFAIL_EN is defined.
module adder_bist_4bit #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] a_o,
  output logic [3:0] b_o,
  output logic       cin_o,
  input  logic [3:0] s_i,
  input  logic       cout_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] err_cnt,
  output logic       ff_valid,
  output logic [8:0] ff_vec,
  output logic [4:0] ff_obs
);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(SETTLE - 1);
  localparam logic [8:0] VEC_LAST  = 9'h1FF;
  localparam logic [9:0] ERR_MAX   = 10'd512;

  state_t     state, state_n;
  logic [8:0] vec, vec_n;
  logic [3:0] hold, hold_n;
  logic       busy_n, done_n, pass_n, clr_ff;
  logic [9:0] err_n;
  logic [4:0] expect_sum;
  logic       mismatch;

  // vec is {cin, A, B}, so a plain increment walks cin outer, A middle, B inner
  assign a_o   = vec[7:4];
  assign b_o   = vec[3:0];
  assign cin_o = vec[8];

  assign expect_sum = {1'b0, vec[7:4]} + {1'b0, vec[3:0]} + {4'b0000, vec[8]};
  assign mismatch   = (state == CHECK) && ({cout_i, s_i} != expect_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      vec     <= '0;
      hold    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_n;
      vec     <= vec_n;
      hold    <= hold_n;
      busy    <= busy_n;
      done    <= done_n;
      pass    <= pass_n;
      err_cnt <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    vec_n   = vec;
    hold_n  = hold;
    busy_n  = busy;
    done_n  = done;
    pass_n  = pass;
    err_n   = err_cnt;
    clr_ff  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = APPLY;
          vec_n   = '0;
          hold_n  = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          err_n   = '0;
          clr_ff  = 1'b1;
        end
      end
      APPLY: begin
        if (abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b0;
          pass_n  = 1'b0;
        end else if (hold == HOLD_LAST) begin
          hold_n  = '0;
          state_n = CHECK;
        end else begin
          hold_n = hold + 4'd1;
        end
      end
      CHECK: begin
        if (abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b0;
          pass_n  = 1'b0;
        end else begin
          if (mismatch && (err_cnt != ERR_MAX)) err_n = err_cnt + 10'd1;
          if (vec == VEC_LAST) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_n == '0);
          end else begin
            vec_n   = vec + 9'd1;
            state_n = APPLY;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef ADDER_BIST_FIRSTFAIL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_valid <= 1'b0;
      ff_vec   <= '0;
      ff_obs   <= '0;
    end else if (clr_ff) begin
      ff_valid <= 1'b0;
      ff_vec   <= '0;
      ff_obs   <= '0;
    end else if (mismatch && !abort && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_vec   <= vec;
      ff_obs   <= {cout_i, s_i};
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_ff;
  assign ff_valid   = 1'b0;
  assign ff_vec     = '0;
  assign ff_obs     = '0;
`endif

endmodule

// File: tb/tb_adder_bist_4bit.sv
// tb/tb_adder_bist_4bit.sv - scoreboard bench for adder_bist_4bit with fault-injected adder stub
module tb_adder_bist_4bit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [3:0] a1, b1, s1;
  logic       cin1, cout1, busy1, done1, pass1, ffv1;
  logic [9:0] err1;
  logic [8:0] ffvec1;
  logic [4:0] ffobs1;
  logic [4:0] sa0 = '0, sa1 = '0;

  logic       start3 = 1'b0, abort3 = 1'b0;
  logic [3:0] a3, b3, s3;
  logic       cin3, cout3, busy3, done3, pass3, ffv3;
  logic [9:0] err3;
  logic [8:0] ffvec3;
  logic [4:0] ffobs3;

  // adder under test: ideal sum with stuck-at-0/stuck-at-1 bit masks
  logic [4:0] sum1;
  assign sum1 = ({1'b0, a1} + {1'b0, b1} + {4'b0000, cin1}) & ~sa0 | sa1;
  assign {cout1, s1} = sum1;
  assign {cout3, s3} = {1'b0, a3} + {1'b0, b3} + {4'b0000, cin3};

  adder_bist_4bit #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .a_o(a1), .b_o(b1), .cin_o(cin1), .s_i(s1), .cout_i(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .ff_valid(ffv1), .ff_vec(ffvec1), .ff_obs(ffobs1));

  adder_bist_4bit #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3),
    .a_o(a3), .b_o(b3), .cin_o(cin3), .s_i(s3), .cout_i(cout3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .ff_valid(ffv3), .ff_vec(ffvec3), .ff_obs(ffobs3));

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    int         err;
    bit         pass;
    bit         ffv;
    logic [8:0] ffvec;
    logic [4:0] ffobs;
    int         done_cyc;
  } exp_t;
  exp_t sbq[$];

  // reference: walk the first nvec vectors in spec order and tally mismatches
  task automatic model(input int nvec, output exp_t e);
    int idx;
    logic [4:0] good, obs;
    e = '{0, 1'b0, 1'b0, 9'd0, 5'd0, 0};
    idx = 0;
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          if (idx < nvec) begin
            good = 5'(a + b + c);
            obs  = good & ~sa0 | sa1;
            if (obs != good) begin
              if (e.err < 512) e.err++;
`ifdef ADDER_BIST_FIRSTFAIL_EN
              if (!e.ffv) begin
                e.ffv   = 1'b1;
                e.ffvec = 9'(idx);
                e.ffobs = obs;
              end
`endif
            end
          end
          idx++;
        end
    e.pass = (e.err == 0);
  endtask

  logic done1_q = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      done1_q = 1'b0;
    end else begin
      if (!done1) chk("pass_without_done", pass1, 0);
      if (done1 && !done1_q) begin
        if (sbq.size() == 0) fail("unexpected_done");
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_latency", cyc, e.done_cyc);
          chk("err_cnt", err1, e.err);
          chk("pass", pass1, e.pass);
          chk("busy_at_done", busy1, 0);
          chk("ff_valid", ffv1, e.ffv);
          chk("ff_vec", ffvec1, e.ffvec);
          chk("ff_obs", ffobs1, e.ffobs);
        end
      end
      done1_q = done1;
    end
  end

  logic [8:0] prev3 = 9'h1FF;
  int len3 = 0;
  always @(negedge clk) begin
    if (busy3) begin
      if ({cin3, a3, b3} !== prev3) begin
        if (len3 > 0) chk("settle3_hold", len3, 4);
        len3  = 1;
        prev3 = {cin3, a3, b3};
      end else len3++;
    end
  end

  task automatic pulse_start1();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
  endtask

  task automatic issue_run(input logic [4:0] m0, input logic [4:0] m1);
    exp_t e;
    @(negedge clk);
    sa0 = m0;
    sa1 = m1 & ~m0;
    model(512, e);
    pulse_start1();
    e.done_cyc = cyc + 1024;
    sbq.push_back(e);
    chk("start_clears_err", err1, 0);
    chk("start_busy", busy1, 1);
    chk("start_done_low", done1, 0);
  endtask

  task automatic wait_run1();
    int t = 0;
    while ((sbq.size() != 0 || !done1) && t < 3000) begin
      @(negedge clk); t++;
    end
    if (t >= 3000) fail("run_timeout");
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, a1, 0);
    chk({tag, "_b"}, b1, 0);
    chk({tag, "_cin"}, cin1, 0);
    chk({tag, "_busy"}, busy1, 0);
    chk({tag, "_done"}, done1, 0);
    chk({tag, "_pass"}, pass1, 0);
    chk({tag, "_err"}, err1, 0);
    chk({tag, "_ffv"}, ffv1, 0);
    chk({tag, "_ffvec"}, ffvec1, 0);
    chk({tag, "_ffobs"}, ffobs1, 0);
  endtask

  initial begin
    exp_t ea;
    int t;
    int k3;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    issue_run(5'b00000, 5'b00000);
    wait_run1();
    issue_run(5'b00001, 5'b00000);
    wait_run1();
    chk("s0_sa0_err", err1, 256);
    issue_run(5'b10000, 5'b00000);
    repeat (200) @(negedge clk);
    pulse_start1();
    wait_run1();
    chk("cout_sa0_err", err1, 256);
    for (int r = 0; r < 3; r++) begin
      issue_run(5'($urandom), 5'($urandom));
      wait_run1();
    end

    // abort when vector 100 is first presented
    @(negedge clk);
    sa0 = 5'b00001; sa1 = '0;
    model(100, ea);
    pulse_start1();
    t = 0;
    while ({cin1, a1, b1} != 9'd100 && t < 2000) begin
      @(negedge clk); t++;
    end
    if (t >= 2000) fail("abort_vec_timeout");
    abort1 = 1'b1;
    @(negedge clk); abort1 = 1'b0;
    chk("abort_busy", busy1, 0);
    chk("abort_done", done1, 0);
    chk("abort_err_kept", err1, ea.err);
    repeat (1100) @(negedge clk);
    chk("abort_no_done", done1, 0);

    // async reset 300 cycles into a run
    issue_run(5'b00000, 5'b00000);
    repeat (300) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("midrun_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue_run(5'b00000, 5'b00000);
    wait_run1();
    chk("post_reset_pass", pass1, 1);

    // SETTLE=3 instance
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    k3 = cyc;
    t = 0;
    while (!done3 && t < 3000) begin
      @(negedge clk); t++;
    end
    if (t >= 3000) fail("settle3_timeout");
    chk("settle3_latency", cyc, k3 + 2048);
    chk("settle3_err", err3, 0);
    chk("settle3_pass", pass3, 1);
    chk("settle3_ffv", ffv3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adder_bist_4bit.md
ADDER_BIST_4BIT -- requirements
Module: adder_bist_4bit

Interface
REQ-001 Parameter SETTLE, default 1, meaning clock cycles each vector is held on a_o/b_o/cin_o before the adder response is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse; begins an exhaustive run when idle.
REQ-005 abort  input  1  terminates a run in progress.
REQ-006 a_o  output  4  operand A driven to the adder under test.
REQ-007 b_o  output  4  operand B driven to the adder under test.
REQ-008 cin_o  output  1  carry-in driven to the adder under test.
REQ-009 s_i  input  4  sum returned by the adder under test.
REQ-010 cout_i  input  1  carry-out returned by the adder under test.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  high after a completed run, until the next start or reset.
REQ-013 pass  output  1  valid with done; high iff err_cnt is zero.
REQ-014 err_cnt  output  10  count of mismatching vectors in the current or last run.
REQ-015 ff_valid / ff_vec[8:0] / ff_obs[4:0]  outputs  first-failure flag, the failing {cin,A,B}, and the observed {cout,S}.

Function
REQ-016 FSM states are IDLE, APPLY, CHECK and DONE; all outputs are registered.
REQ-017 IDLE: start=1 -> APPLY with {cin,A,B}=0, err_cnt cleared, ff_* cleared, done=0, busy=1.
REQ-018 Vector order is cin outer (0 then 1), A middle (0..15), B inner (0..15): 512 vectors total.
REQ-019 APPLY holds the vector for SETTLE cycles and then moves to CHECK.
REQ-020 CHECK compares {cout_i,s_i} against the 5-bit value A+B+cin; a mismatch increments err_cnt (saturating at 512, never wrapping).
REQ-021 CHECK on a non-final vector advances to the next vector and returns to APPLY, so each vector takes SETTLE+1 cycles.
REQ-022 CHECK on the final vector ({1,15,15}) -> DONE with busy=0, done=1, and pass=(err_cnt==0) including that vector's result.
REQ-023 A full run lasts exactly 512*(SETTLE+1) cycles from the cycle after start until done rises.
REQ-024 start while busy is ignored; start in DONE begins a new run exactly as from IDLE.
REQ-025 abort while busy -> IDLE next cycle with busy=0 and done=0; err_cnt is retained; abort has priority over a same-cycle CHECK completion.
REQ-026 pass is 0 whenever done is 0.

Reset
REQ-027 rst asserted, at any time including mid-run, forces IDLE immediately.
REQ-028 On reset all outputs are zero: a_o=0, b_o=0, cin_o=0, busy=0, done=0, pass=0, err_cnt=0, ff_valid=0, ff_vec=0, ff_obs=0.

Configuration
REQ-029 Macro ADDER_BIST_FIRSTFAIL_EN defined: on the first mismatch of a run, ff_valid=1 and ff_vec/ff_obs capture that vector and response; they hold until the next start or reset.
REQ-030 Macro ADDER_BIST_FIRSTFAIL_EN undefined: ff_valid, ff_vec and ff_obs are constant 0 and no capture registers are built; all other behaviour is unchanged.

Verification
REQ-031 Correct behavioural adder, SETTLE=1, start pulse -> done rises 1024 cycles later with err_cnt=0, pass=1, ff_valid=0.
REQ-032 Adder with S[0] stuck at 0 -> err_cnt=256, pass=0; with the macro, ff_vec={0,0,1} (cin=0, A=0, B=1) and ff_obs=5'b00000.
REQ-033 Adder with cout stuck at 0 -> err_cnt=256 (120 vectors with cin=0 plus 136 with cin=1), pass=0.
REQ-034 rst asserted at cycle 300 of a run -> all outputs zero in the same cycle; a following start completes a clean run with pass=1.
REQ-035 abort at vector 100 -> busy=0 and done=0 next cycle; start pulsed during busy has no effect; start in DONE restarts with err_cnt=0.
REQ-036 SETTLE=3 with a correct adder -> done 2048 cycles after start, and each vector is stable on a_o/b_o/cin_o for 4 cycles.
